// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and flag payload for the sequential execute unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_CBZ  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_LSL  = 4'd10;
  localparam logic [3:0] ALU_LSR  = 4'd11;
  localparam logic [3:0] ALU_NAND = 4'd12;
  localparam logic [3:0] ALU_MOV  = 4'd13;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } aluState_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } aluFlags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier: one partial product per cycle, full product
// presented combinationally on the final step alongside done_c.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     partSum;

  // Multiplier sits in the low half of acc and is consumed LSB first.
  always_comb begin
    partSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, mcand});
    product_c = {partSum, acc[WIDTH-1:1]};
    done_c    = busy && (count == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CW'(WIDTH - 1);
      mcand <= a;
      acc   <= {WIDTH'(0), b};
    end else if (busy) begin
      acc   <= product_c;
      count <= count - 1'b1;
      if (count == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execute unit: single-cycle ALU ops plus a multi-cycle multiplier,
// with a registered result/flag stage that holds while the consumer stalls.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluControlCode,
  input  logic [WIDTH-1:0] readData1,
  input  logic [WIDTH-1:0] readData2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             carryBit,
  output logic             ovfFlag,
  output logic             illegalOp
);

  localparam int unsigned SHW = $clog2(WIDTH);

  aluState_t          state, nextState;
  aluFlags_t          flags, flagsNext;
  logic [WIDTH-1:0]   resNext;
  logic               wrEn, accept, mulStart, mulBusy, mulDone;
  logic [2*WIDTH-1:0] mulProd;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sumExt, diffExt, shlExt, shrExt;

  assign in_ready = (state == IDLE) && !mulBusy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign zeroFlag  = flags.zero;
  assign negFlag   = flags.neg;
  assign carryBit  = flags.carry;
  assign ovfFlag   = flags.ovf;
  assign illegalOp = flags.illegal;

  alu_mul_seq #(.WIDTH(WIDTH)) uMul (
    .clock    (clock),
    .reset    (reset),
    .start    (mulStart),
    .a        (readData1),
    .b        (readData2),
    .busy     (mulBusy),
    .done_c   (mulDone),
    .product_c(mulProd)
  );

  // Extended arithmetic: the extra bit catches carry/borrow or the last bit shifted out.
  always_comb begin
    shamt   = readData2[SHW-1:0];
    sumExt  = {1'b0, readData1} + {1'b0, readData2};
    diffExt = {1'b0, readData1} - {1'b0, readData2};
    shlExt  = {1'b0, readData1} << shamt;
    shrExt  = {readData1, 1'b0} >> shamt;
  end

  always_comb begin
    nextState = state;
    wrEn      = 1'b0;
    mulStart  = 1'b0;
    resNext   = '0;
    flagsNext = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (aluControlCode == ALU_MUL) begin
            mulStart  = 1'b1;
            nextState = MUL_BUSY;
          end else begin
            wrEn = 1'b1;
            case (aluControlCode)
              ALU_ADD: begin
                resNext         = sumExt[WIDTH-1:0];
                flagsNext.carry = sumExt[WIDTH];
                flagsNext.ovf   = (readData1[WIDTH-1] == readData2[WIDTH-1]) &&
                                  (sumExt[WIDTH-1] != readData1[WIDTH-1]);
              end
              ALU_SUB: begin
                resNext         = diffExt[WIDTH-1:0];
                flagsNext.carry = !diffExt[WIDTH];
                flagsNext.ovf   = (readData1[WIDTH-1] != readData2[WIDTH-1]) &&
                                  (diffExt[WIDTH-1] != readData1[WIDTH-1]);
              end
              ALU_OR:   resNext = readData1 | readData2;
              ALU_NOR:  resNext = ~(readData1 | readData2);
              ALU_AND:  resNext = readData1 & readData2;
              ALU_XOR:  resNext = readData1 ^ readData2;
              ALU_NAND: resNext = ~(readData1 & readData2);
              ALU_CBZ, ALU_MOV: resNext = readData2;
              ALU_LSL: begin
                resNext         = shlExt[WIDTH-1:0];
                flagsNext.carry = shlExt[WIDTH];
              end
              ALU_LSR: begin
                resNext         = shrExt[WIDTH:1];
                flagsNext.carry = shrExt[0];
              end
              default: flagsNext.illegal = 1'b1;
            endcase
          end
        end
      end
      MUL_BUSY: begin
        if (mulDone) begin
          wrEn            = 1'b1;
          resNext         = mulProd[WIDTH-1:0];
          flagsNext.carry = |mulProd[2*WIDTH-1:WIDTH];
          nextState       = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    flagsNext.zero = (resNext == '0);
    flagsNext.neg  = resNext[WIDTH-1];
  end

  // A write on the same edge as a drain keeps out_valid high with fresh data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      state <= nextState;
      if (wrEn) begin
        out_valid <= 1'b1;
        result    <= resNext;
        flags     <= flagsNext;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: vector table for single-cycle ops plus
// hand-written multiply, stall and reset sequences.
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  aluControlCode;
  logic [31:0] readData1, readData2, result;
  logic        zeroFlag, negFlag, carryBit, ovfFlag, illegalOp;

  int nChecks = 0;
  int nFails  = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluControlCode(aluControlCode),
    .readData1(readData1), .readData2(readData2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .zeroFlag(zeroFlag), .negFlag(negFlag), .carryBit(carryBit),
    .ovfFlag(ovfFlag), .illegalOp(illegalOp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;   // {zero, neg, carry, ovf, illegal}
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] flagVec();
    return {zeroFlag, negFlag, carryBit, ovfFlag, illegalOp};
  endfunction

  task automatic runMul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input logic expCarry);
    int lat;
    int lowReady;
    readData1 = a; readData2 = b; aluControlCode = ALU_MUL; in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    readData1 = 32'hDEAD_BEEF; readData2 = 32'h1234_5678;
    lat = 0;
    lowReady = in_ready ? 0 : 1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!in_ready) lowReady++;
    end
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_ready_low", 64'(lowReady), 64'd32);
    check("mul_result", 64'(result), 64'(expRes));
    check("mul_carry", 64'(carryBit), 64'(expCarry));
    check("mul_ovf", 64'(ovfFlag), 64'd0);
    step();
    check("mul_drain", 64'(out_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD,  32'd15,         32'd15,         32'd30,         5'b00000};
    vecs[1]  = '{ALU_SUB,  32'd15,         32'd15,         32'd0,          5'b10100};
    vecs[2]  = '{ALU_AND,  32'd5,          32'd10,         32'd0,          5'b10000};
    vecs[3]  = '{ALU_OR,   32'd5,          32'd10,         32'd15,         5'b00000};
    vecs[4]  = '{ALU_XOR,  32'd5,          32'd10,         32'd15,         5'b00000};
    vecs[5]  = '{ALU_NOR,  32'd5,          32'd10,         32'hFFFF_FFF0,  5'b01000};
    vecs[6]  = '{ALU_NAND, 32'd5,          32'd10,         32'hFFFF_FFFF,  5'b01000};
    vecs[7]  = '{ALU_MOV,  32'd5,          32'd10,         32'd10,         5'b00000};
    vecs[8]  = '{ALU_CBZ,  32'd5,          32'd10,         32'd10,         5'b00000};
    vecs[9]  = '{ALU_ADD,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  5'b01010};
    vecs[10] = '{ALU_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          5'b10100};
    vecs[11] = '{ALU_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  5'b01000};
    vecs[12] = '{ALU_SUB,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  5'b00110};
    vecs[13] = '{ALU_LSL,  32'h8000_0001,  32'd1,          32'd2,          5'b00100};
    vecs[14] = '{ALU_LSL,  32'h1234_5678,  32'd0,          32'h1234_5678,  5'b00000};
    vecs[15] = '{ALU_LSR,  32'd3,          32'd1,          32'd1,          5'b00100};
    vecs[16] = '{ALU_LSR,  32'h0000_00F0,  32'd4,          32'h0000_000F,  5'b00000};
    vecs[17] = '{ALU_LSL,  32'd1,          32'd33,         32'd2,          5'b00000};
    vecs[18] = '{4'd0,     32'd7,          32'd9,          32'd0,          5'b10001};
    vecs[19] = '{4'd14,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          5'b10001};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluControlCode = 4'd0; readData1 = '0; readData2 = '0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flagVec()), 64'd0);
    reset = 1'b0;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back single-cycle ops with in_valid held high
    for (int i = 0; i < 20; i++) begin
      aluControlCode = vecs[i].code;
      readData1 = vecs[i].a; readData2 = vecs[i].b;
      in_valid = 1'b1;
      step();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'(flagVec()), 64'(vecs[i].flg));
    end
    in_valid = 1'b0;
    step();
    check("drain_after_vecs", 64'(out_valid), 64'd0);

    runMul(32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b1);
    runMul(32'd7, 32'd6, 32'd42, 1'b0);
    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);

    // Stall: result holds, a pending MUL is refused, then drain+refill on one edge
    out_ready = 1'b0;
    aluControlCode = ALU_ADD; readData1 = 32'd1; readData2 = 32'd2; in_valid = 1'b1;
    step();
    check("stall_first", 64'(result), 64'd3);
    aluControlCode = ALU_MUL; readData1 = 32'd9; readData2 = 32'd9;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_ready%0d", i), 64'(in_ready), 64'd0);
      step();
      check($sformatf("stall_hold%0d", i), 64'({out_valid, result}), {31'd0, 1'b1, 32'd3});
    end
    aluControlCode = ALU_ADD; readData1 = 32'd4; readData2 = 32'd4;
    out_ready = 1'b1;
    #1;
    check("refill_ready", 64'(in_ready), 64'd1);
    step();
    check("refill_valid", 64'(out_valid), 64'd1);
    check("refill_result", 64'(result), 64'd8);
    in_valid = 1'b0;
    step();
    check("refill_drain", 64'(out_valid), 64'd0);

    // Reset asserted ten cycles into a multiply
    aluControlCode = ALU_MUL; readData1 = 32'd7; readData2 = 32'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("abort_ready", 64'(in_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("abort_no_partial", 64'(seen), 64'd0);
    end

    aluControlCode = 4'd15; readData1 = 32'd3; readData2 = 32'd4; in_valid = 1'b1;
    step();
    check("illegal_result", 64'(result), 64'd0);
    check("illegal_flags", 64'(flagVec()), 64'b10001);
    aluControlCode = ALU_ADD; readData1 = 32'd1; readData2 = 32'd1;
    step();
    check("legal_after_illegal", 64'({result, flagVec()}), {27'd0, 32'd2, 5'b00000});
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised successor to the single-cycle ALU: a WIDTH-bit execute unit with valid/ready handshakes on both sides, a registered result/flag stage, and a multi-cycle shift-add multiplier. It sits between operand preparation (readData1/readData2 source) and the data cache / PC (result and zeroFlag consumers). It replaces the combinational ALU so that a stalled downstream stage no longer loses results.

## Interface
- WIDTH, 32, operand/result width; legal values 8..64, power of two
- SHW, $clog2(WIDTH), shift-amount width, derived; not overridden
- clock  in  1  rising-edge clock for the unit
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept this cycle
- aluControlCode  in  4  operation code (see Operation)
- readData1  in  WIDTH  operand A
- readData2  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zeroFlag  out  1  result == 0
- negFlag  out  1  result[WIDTH-1]
- carryBit  out  1  carry / no-borrow / multiply high-half nonzero
- ovfFlag  out  1  signed overflow (add/sub only, else 0)
- illegalOp  out  1  unsupported code was executed

## Operation
- Codes: 2 ADD A+B; 3 SUB A-B; 4 OR; 5 NOR; 6 AND; 7 CBZ (result=B); 8 MUL (low WIDTH bits of A*B, unsigned); 9 XOR; 10 LSL A<<B[SHW-1:0]; 11 LSR A>>B[SHW-1:0] (logical); 12 NAND; 13 MOV (result=B). All other codes: result=0, illegalOp=1, zeroFlag=1, other flags 0.
- Accept when in_valid && in_ready at a rising edge; operands and code are captured that edge and ignored afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- States: IDLE, MUL_BUSY. IDLE + accept of a non-MUL code -> write output register, stay IDLE. IDLE + accept of MUL -> MUL_BUSY, counter=WIDTH-1. MUL_BUSY: one shift-add step per cycle into a 2*WIDTH accumulator; on the step with counter==0 write output register, return to IDLE.
- Output register: out_valid set on write; cleared when out_valid && out_ready and no new write that edge; a write and a drain on the same edge leaves out_valid=1 with the new data (back-to-back throughput 1 op/cycle for single-cycle ops).
- Result/flags hold stable while out_valid && !out_ready.
- Carry: ADD = bit WIDTH of sum; SUB = 1 when A>=B unsigned; shifts = last bit shifted out (0 if amount 0); MUL = OR of high WIDTH product bits; logic/MOV/CBZ = 0.
- Overflow: ADD/SUB standard two's-complement rule; otherwise 0.
- illegalOp is 0 for every legal code.

## Timing
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, all flags 0, illegalOp=0, counter=0; in_ready=1 from the first edge after release.
- Single-cycle ops: accept at edge k -> out_valid=1 after edge k (latency 1).
- MUL: accept at edge k -> in_ready=0 after k; out_valid=1 after edge k+WIDTH (latency WIDTH). MUL is not accepted while out_valid && !out_ready.
- Reset mid-MUL aborts; no partial result is ever presented.
- No combinational path from in_valid or operands to any output; in_ready depends combinationally on out_ready only.

## Structure
- Package alu_pkg: opcode localparams (ALU_ADD=2 ... ALU_MOV=13), state enum {IDLE, MUL_BUSY}.
- Sub-module alu_mul_seq: start/busy/done shift-add multiplier, WIDTH-parametrised, owning the accumulator and counter; top holds FSM, combinational datapath and output register.

## Test plan
- WIDTH=32, A=15, B=15, ADD, out_ready=1 -> next cycle result=30, zeroFlag=0, carryBit=0; then SUB -> result=0, zeroFlag=1, carryBit=1.
- A=5, B=10 sequence AND/OR/XOR/NOR/NAND/MOV/CBZ back-to-back, in_valid held high -> one result per cycle: 0, 15, 15, 0xFFFFFFF0, 0xFFFFFFFF, 10, 10.
- ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, ovfFlag=1, negFlag=1; ADD A=0xFFFFFFFF, B=1 -> result=0, carryBit=1, zeroFlag=1.
- MUL A=0x10000, B=0x10003 -> in_ready low 32 cycles, then result=0x30000, carryBit=1; MUL 7*6 -> 42, carryBit=0, latency exactly 32.
- out_ready=0 after ADD 1+2: result=3 held, in_ready=0 for 5 cycles; raise out_ready with new ADD 4+4 pending -> drain and refill same edge, result=8.
- Assert reset at MUL cycle 10 -> out_valid=0, result=0 immediately; code 15 after release -> illegalOp=1, result=0, zeroFlag=1.
